i2c_target_regs: RTL and testbench

//  I2C target (responder) for the on-board I2C bus driven by the LM32 I2C master at 0x60000000.

---
 rtl/i2c_target_regs.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing an NREGS x 8-bit register file, with a local write port for the sensor block.
// Define I2C_TARGET_RO_EN to make the upper half of the register file read-only from the bus.
module i2c_target_regs #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h63,
  parameter int unsigned NREGS      = 16,
  parameter int unsigned FILTER_LEN = 3,
  localparam int unsigned AW        = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdat,
  output logic          i2c_wr_stb,
  output logic [AW-1:0] i2c_wr_addr,
  output logic [7:0]    i2c_wr_dat,
  output logic          busy
);

  localparam int unsigned CW = $clog2(FILTER_LEN) + 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK
  } state_t;

  // Bit 1 carries SCL, bit 0 carries SDA; idle bus level is high.
  logic [1:0]    sync1_q, sync2_q, filt_q, filt_prev_q;
  logic [CW-1:0] fcnt_q [2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      filt_q      <= '1;
      filt_prev_q <= '1;
      for (int unsigned i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q     <= {scl_i, sda_i};
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + CW'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
  always_comb begin
    scl_f    = filt_q[1];
    sda_f    = filt_q[0];
    scl_rise = scl_f & ~filt_prev_q[1];
    scl_fall = ~scl_f & filt_prev_q[1];
    start_c  = scl_f & filt_prev_q[1] & filt_prev_q[0] & ~sda_f;
    stop_c   = scl_f & filt_prev_q[1] & ~filt_prev_q[0] & sda_f;
  end

  state_t        state_q;
  logic [3:0]    bitcnt_q;
  logic [7:0]    sh_q;
  logic [AW-1:0] ptr_q;
  logic          rd_q, sda_oe_q, busy_q, stb_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_dat_q;
  logic [7:0]    regs_q [NREGS];
  logic [7:0]    byte_in;
  logic          wr_ok;

  always_comb begin
    byte_in = {sh_q[6:0], sda_f};
`ifdef I2C_TARGET_RO_EN
    wr_ok   = ~ptr_q[AW-1];
`else
    wr_ok   = 1'b1;
`endif
  end

  // ACK states use sda_oe_q as their phase: first SCL fall drives the ACK, second ends it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      sh_q      <= '0;
      ptr_q     <= '0;
      rd_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      stb_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
    end else begin
      stb_q <= 1'b0;
      if (start_c) begin
        state_q  <= ADDR;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
      end else if (stop_c) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: ;
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              sh_q     <= byte_in;
              bitcnt_q <= bitcnt_q + 4'd1;
              if (bitcnt_q == 4'd7) begin
                if (state_q == ADDR) begin
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                    state_q <= ADDR_ACK;
                    rd_q    <= byte_in[0];
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                  end
                end else if (state_q == PTR) begin
                  ptr_q   <= byte_in[AW-1:0];
                  state_q <= PTR_ACK;
                end else begin
                  state_q <= WACK;
                end
              end
            end
          end
          ADDR_ACK, PTR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                bitcnt_q <= '0;
                if (state_q == PTR_ACK) begin
                  state_q <= WDATA;
                end else if (rd_q) begin
                  state_q  <= RDATA;
                  sh_q     <= regs_q[ptr_q];
                  sda_oe_q <= ~regs_q[ptr_q][7];
                end else begin
                  state_q <= PTR;
                end
              end
            end
          end
          WACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
                ptr_q    <= ptr_q + AW'(1);
                if (wr_ok) begin
                  stb_q     <= 1'b1;
                  wr_addr_q <= ptr_q;
                  wr_dat_q  <= sh_q;
                end
              end else begin
                sda_oe_q <= 1'b0;
                bitcnt_q <= '0;
                state_q  <= WDATA;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q + 4'd1;
              if (bitcnt_q == 4'd7) ptr_q <= ptr_q + AW'(1);
            end else if (scl_fall) begin
              if (bitcnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= RACK;
              end else begin
                sda_oe_q <= ~sh_q[6];
                sh_q     <= {sh_q[6:0], 1'b0};
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (sda_f) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else if (scl_fall) begin
              state_q  <= RDATA;
              bitcnt_q <= '0;
              sh_q     <= regs_q[ptr_q];
              sda_oe_q <= ~regs_q[ptr_q][7];
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // The I2C write is applied after the local one so it wins on a same-register collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (loc_we) regs_q[loc_addr] <= loc_wdat;
      if (stb_q)  regs_q[wr_addr_q] <= wr_dat_q;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign i2c_wr_stb  = stb_q;
  assign i2c_wr_addr = wr_addr_q;
  assign i2c_wr_dat  = wr_dat_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged open-drain master plus write-strobe monitor.
`timescale 1ns/1ps
module tb_i2c_target_regs;
  localparam int Q  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          scl_m = 1'b1, sda_m = 1'b1;
  logic          sda_bus, sda_oe;
  logic          loc_we, loc_we_t = 1'b0;
  logic [AW-1:0] loc_addr, loc_addr_t = '0;
  logic [7:0]    loc_wdat, loc_wdat_t = '0;
  logic          i2c_wr_stb, busy;
  logic [AW-1:0] i2c_wr_addr;
  logic [7:0]    i2c_wr_dat;
  logic          coll_arm = 1'b0;
  logic [AW-1:0] coll_addr = '0;

  int vectors = 0, miscompares = 0;
  int st_addr[$];
  int st_dat[$];
  bit oe_seen = 0, busy_seen = 0;

  always #10 clk = ~clk;

  assign sda_bus  = sda_m & ~sda_oe;
  // Collision mode fires the local write combinationally in the I2C strobe cycle.
  assign loc_we   = loc_we_t | (coll_arm & i2c_wr_stb);
  assign loc_addr = coll_arm ? coll_addr : loc_addr_t;
  assign loc_wdat = coll_arm ? 8'hEE : loc_wdat_t;

  i2c_target_regs #(.SLAVE_ADDR(7'h63), .NREGS(16), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdat(loc_wdat),
    .i2c_wr_stb(i2c_wr_stb), .i2c_wr_addr(i2c_wr_addr), .i2c_wr_dat(i2c_wr_dat),
    .busy(busy)
  );

  always @(negedge clk) begin
    if (i2c_wr_stb) begin
      st_addr.push_back(int'(i2c_wr_addr));
      st_dat.push_back(int'(i2c_wr_dat));
    end
    if (sda_oe) oe_seen = 1;
    if (busy)   busy_seen = 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
    loc_addr_t = a; loc_wdat_t = d; loc_we_t = 1'b1;
    wait_clk(1);
    loc_we_t = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b0; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic clk_bit(input logic b, input bit glitch, output logic s);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    s = sda_bus;
    if (glitch) begin
      scl_m = 1'b0; wait_clk(2);
      scl_m = 1'b1; wait_clk(Q-2);
    end else begin
      wait_clk(Q);
    end
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], i == gbit, s);
    clk_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clk_bit(~mack, 1'b0, s);
  endtask

  task automatic read_two(input logic [7:0] ptr, output logic [7:0] d0, output logic [7:0] d1);
    logic a;
    i2c_start(); write_byte(8'hC6, -1, a); write_byte(ptr, -1, a);
    i2c_start(); write_byte(8'hC7, -1, a);
    read_byte(1'b1, d0); read_byte(1'b0, d1);
    i2c_stop();
  endtask

  task automatic test_reset();
    wait_clk(3); rst = 1'b1; wait_clk(3);
    vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    vectors++; if (i2c_wr_stb !== 1'b0) begin miscompares++; $display("FAIL reset_stb: got %b expected 0", i2c_wr_stb); end
    vectors++; if (i2c_wr_addr !== 4'h0) begin miscompares++; $display("FAIL reset_wr_addr: got %h expected 0", i2c_wr_addr); end
    vectors++; if (i2c_wr_dat !== 8'h00) begin miscompares++; $display("FAIL reset_wr_dat: got %h expected 00", i2c_wr_dat); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write();
    logic acks [4];
    logic [7:0] b [4];
    logic [7:0] d0, d1;
    b[0] = 8'hC6; b[1] = 8'h02; b[2] = 8'hA5; b[3] = 8'h5A;
    st_addr.delete(); st_dat.delete();
    i2c_start();
    for (int i = 0; i < 4; i++) write_byte(b[i], -1, acks[i]);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (acks[i] !== 1'b1) begin miscompares++; $display("FAIL write_ack%0d: got %b expected 1", i, acks[i]); end
    end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL write_busy_before_stop: got %b expected 1", busy); end
    i2c_stop();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    vectors++;
    if (st_addr.size() != 2) begin miscompares++; $display("FAIL write_stb_count: got %0d expected 2", st_addr.size()); end
    else if (st_addr[0] != 2 || st_dat[0] != 'hA5 || st_addr[1] != 3 || st_dat[1] != 'h5A) begin
      miscompares++;
      $display("FAIL write_stb_vals: got %0d/%h %0d/%h expected 2/a5 3/5a", st_addr[0], st_dat[0], st_addr[1], st_dat[1]);
    end
    read_two(8'h02, d0, d1);
    vectors++; if (d0 !== 8'hA5 || d1 !== 8'h5A) begin miscompares++; $display("FAIL write_readback: got %h %h expected a5 5a", d0, d1); end
  endtask

  task automatic test_rep_start_read();
    logic a;
    logic [7:0] d0, d1, d2;
    loc_write(4'd4, 8'h37); loc_write(4'd5, 8'h81); loc_write(4'd6, 8'h6C);
    st_addr.delete(); st_dat.delete();
    i2c_start(); write_byte(8'hC6, -1, a); write_byte(8'h04, -1, a);
    i2c_start(); write_byte(8'hC7, -1, a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL rsr_read_addr_ack: got %b expected 1", a); end
    read_byte(1'b1, d0); read_byte(1'b0, d1);
    i2c_stop();
    vectors++; if (d0 !== 8'h37) begin miscompares++; $display("FAIL rsr_byte0: got %h expected 37", d0); end
    vectors++; if (d1 !== 8'h81) begin miscompares++; $display("FAIL rsr_byte1: got %h expected 81", d1); end
    i2c_start(); write_byte(8'hC7, -1, a); read_byte(1'b0, d2); i2c_stop();
    vectors++; if (d2 !== 8'h6C) begin miscompares++; $display("FAIL rsr_pointer_persist: got %h expected 6c", d2); end
    vectors++; if (st_addr.size() != 0) begin miscompares++; $display("FAIL rsr_no_writes: got %0d expected 0", st_addr.size()); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    st_addr.delete(); st_dat.delete();
    i2c_start();
    oe_seen = 0; busy_seen = 0;
    write_byte(8'hA0, -1, a0); write_byte(8'h55, -1, a1);
    i2c_stop();
    vectors++; if (a0 !== 1'b0 || a1 !== 1'b0) begin miscompares++; $display("FAIL wrong_addr_ack: got %b%b expected 00", a0, a1); end
    vectors++; if (oe_seen !== 1'b0) begin miscompares++; $display("FAIL wrong_addr_sda_oe: got %b expected 0", oe_seen); end
    vectors++; if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL wrong_addr_busy: got %b expected 0", busy_seen); end
    vectors++; if (st_addr.size() != 0) begin miscompares++; $display("FAIL wrong_addr_writes: got %0d expected 0", st_addr.size()); end
  endtask

  task automatic test_wrap();
    logic a;
    logic [7:0] d0, d1;
    st_addr.delete(); st_dat.delete();
    i2c_start(); write_byte(8'hC6, -1, a); write_byte(8'h0F, -1, a);
    write_byte(8'h11, -1, a); write_byte(8'h22, -1, a); i2c_stop();
    vectors++;
    if (st_addr.size() != 2) begin miscompares++; $display("FAIL wrap_stb_count: got %0d expected 2", st_addr.size()); end
    else if (st_addr[0] != 15 || st_dat[0] != 'h11 || st_addr[1] != 0 || st_dat[1] != 'h22) begin
      miscompares++;
      $display("FAIL wrap_stb_vals: got %0d/%h %0d/%h expected 15/11 0/22", st_addr[0], st_dat[0], st_addr[1], st_dat[1]);
    end
    read_two(8'h0F, d0, d1);
    vectors++; if (d0 !== 8'h11 || d1 !== 8'h22) begin miscompares++; $display("FAIL wrap_readback: got %h %h expected 11 22", d0, d1); end
  endtask

  task automatic test_glitch_collision();
    logic a;
    logic [7:0] d0, d1, d2;
    st_addr.delete(); st_dat.delete();
    i2c_start(); write_byte(8'hC6, -1, a); write_byte(8'h06, -1, a);
    coll_arm = 1'b1; coll_addr = 4'd6;
    write_byte(8'h3C, 3, a);
    coll_addr = 4'd1;
    write_byte(8'h99, 5, a);
    coll_arm = 1'b0;
    i2c_stop();
    vectors++;
    if (st_addr.size() != 2) begin miscompares++; $display("FAIL glitch_stb_count: got %0d expected 2", st_addr.size()); end
    else if (st_addr[0] != 6 || st_dat[0] != 'h3C || st_addr[1] != 7 || st_dat[1] != 'h99) begin
      miscompares++;
      $display("FAIL glitch_stb_vals: got %0d/%h %0d/%h expected 6/3c 7/99", st_addr[0], st_dat[0], st_addr[1], st_dat[1]);
    end
    read_two(8'h06, d0, d1);
    vectors++; if (d0 !== 8'h3C) begin miscompares++; $display("FAIL collision_same_reg: got %h expected 3c", d0); end
    vectors++; if (d1 !== 8'h99) begin miscompares++; $display("FAIL collision_diff_reg_i2c: got %h expected 99", d1); end
    i2c_start(); write_byte(8'hC6, -1, a); write_byte(8'h01, -1, a);
    i2c_start(); write_byte(8'hC7, -1, a); read_byte(1'b0, d2); i2c_stop();
    vectors++; if (d2 !== 8'hEE) begin miscompares++; $display("FAIL collision_diff_reg_local: got %h expected ee", d2); end
  endtask

  task automatic test_reset_mid_read();
    logic a, s;
    logic [7:0] d;
    int n;
    i2c_start(); write_byte(8'hC6, -1, a); write_byte(8'h02, -1, a);
    i2c_start(); write_byte(8'hC7, -1, a);
    clk_bit(1'b1, 1'b0, s);
    vectors++; if (s !== 1'b1) begin miscompares++; $display("FAIL midread_bit7: got %b expected 1", s); end
    n = 0;
    while (sda_oe !== 1'b1 && n < 40) begin wait_clk(1); n++; end
    vectors++; if (sda_oe !== 1'b1) begin miscompares++; $display("FAIL midread_driving: got %b expected 1", sda_oe); end
    rst = 1'b0;
    #1;
    vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL midread_reset_release: got %b expected 0", sda_oe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midread_reset_busy: got %b expected 0", busy); end
    wait_clk(2); sda_m = 1'b1; scl_m = 1'b1; wait_clk(4);
    rst = 1'b1; wait_clk(4);
    loc_write(4'd0, 8'h5E); loc_write(4'd2, 8'h33);
    i2c_start(); write_byte(8'hC7, -1, a); read_byte(1'b0, d); i2c_stop();
    vectors++; if (a !== 1'b1 || d !== 8'h5E) begin miscompares++; $display("FAIL midread_pointer_reset: got ack %b data %h expected 1 5e", a, d); end
  endtask

`ifdef I2C_TARGET_RO_EN
  task automatic test_ro();
    logic a0, a1;
    logic [7:0] d0, d1;
    st_addr.delete(); st_dat.delete();
    i2c_start(); write_byte(8'hC6, -1, a0); write_byte(8'h08, -1, a0);
    write_byte(8'h77, -1, a1); i2c_stop();
    vectors++; if (a1 !== 1'b1) begin miscompares++; $display("FAIL ro_ack: got %b expected 1", a1); end
    vectors++; if (st_addr.size() != 0) begin miscompares++; $display("FAIL ro_no_stb: got %0d expected 0", st_addr.size()); end
    read_two(8'h08, d0, d1);
    vectors++; if (d0 !== 8'h00) begin miscompares++; $display("FAIL ro_unchanged: got %h expected 00", d0); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_rep_start_read();
    test_wrong_addr();
    test_wrap();
    test_glitch_collision();
    test_reset_mid_read();
`ifdef I2C_TARGET_RO_EN
    test_ro();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
